tank_key_decoder: RTL
=====================

Name: tank_key_decoder

Overview:
- Consumes the 8-bit USB HID keycode exported by the SoC's keycode PIO. Produces player-1 tank control: facing direction, move enable, single-cycle fire strobe and pause toggle.
- Sits between the SoC keycode export and the tank motion/bullet logic. Runs on the system clock.
- Filters PIO update glitches and enforces a fire cooldown counted in video frames.

Parameters:
- STABLE_CYCLES, 4: cycles a new keycode must stay unchanged before it is accepted; range 1..255.
- COOLDOWN_FRAMES, 15: frame_tick pulses after a shot before another shot is allowed; range 1..255.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- keycode  in  8  raw HID keycode from the SoC; 0x00 = no key.
- dir  out  2  facing: 0 up, 1 right, 2 down, 3 left.
- move  out  1  high while an accepted direction key is held and not paused.
- fire  out  1  one-cycle shot strobe.
- paused  out  1  pause state, toggled by Enter.
- key_code_q  out  8  currently accepted (filtered) keycode, for debug.

Behaviour:
- Single clock domain: Clk only. Reset is synchronous, active-high.
- Reset values: dir=0, move=0, fire=0, paused=0, key_code_q=0x00, filter count=0, fire FSM=F_IDLE, cooldown=0.
- Key map: W 0x1A→up, D 0x07→right, S 0x16→down, A 0x04→left, Space 0x2C→fire, Enter 0x28→pause. All other codes are unmapped and behave as no key, but are still accepted into key_code_q.
- Stability filter:
  - keycode is registered once (raw_q).
  - If raw_q differs from the candidate, the candidate takes raw_q and the counter clears.
  - Otherwise the counter increments, saturating.
  - When the counter reaches STABLE_CYCLES-1 and candidate≠key_code_q, key_code_q takes the candidate next cycle.
  - Acceptance latency from a keycode change: STABLE_CYCLES+1 cycles.
- accept_evt: one-cycle internal pulse in the cycle key_code_q changes.
- Direction:
  - On accept_evt with a direction code, dir updates in the same cycle as key_code_q.
  - dir holds its last value when the key is released.
  - move = (key_code_q is a direction code) and not paused. It is registered and aligns with key_code_q.
- Pause:
  - On accept_evt with code 0x28, paused toggles.
  - Holding Enter does not re-toggle; a new accept of 0x28 requires an intervening different accepted code.
- Fire FSM (states F_IDLE, F_COOL, F_WAIT_REL):
  - F_IDLE: on accept_evt with 0x2C and not paused, fire=1 for one cycle, cooldown loads COOLDOWN_FRAMES, go to F_COOL.
  - F_COOL: each frame_tick decrements cooldown. At 0, go to F_WAIT_REL if key_code_q==0x2C, else F_IDLE.
  - F_WAIT_REL: go to F_IDLE when key_code_q≠0x2C.
  - Space presses during F_COOL are dropped, not queued.
- Simultaneous frame_tick and accept_evt: both take effect in the same cycle. The decrement happens and the event is evaluated against the pre-update state.
- Pause during F_COOL: cooldown keeps counting, so the timing is frame-accurate.
- Reset mid-cooldown: returns to F_IDLE; the next Space accept fires immediately.
- fire is never high on two consecutive cycles.

Optional Feature:
- Macro: TANK_KEY_AUTOFIRE_EN.
- Defined:
  - In F_COOL, when cooldown reaches 0 and key_code_q==0x2C and not paused, fire=1 and cooldown reloads. The FSM stays in F_COOL.
  - Holding Space fires every COOLDOWN_FRAMES frames. F_WAIT_REL is unused.
- Undefined: one shot per accepted press, exactly as described in Behaviour.

Decomposition:
- Package tank_key_pkg holds:
  - keycode constants KC_W, KC_A, KC_S, KC_D, KC_SPACE, KC_ENTER, KC_NONE.
  - dir_t enum (DIR_UP..DIR_LEFT).
  - fire_state_t enum.
  - function is_dir_code() returning valid + dir.
- One sub-module: key_stable_filter, parameterized by STABLE_CYCLES and WIDTH=8. It outputs key_code_q and accept_evt.
- FSM and mapping stay in the top module.

Test Plan:
- Reset, then keycode=0x07 held 10 cycles → key_code_q=0x07 and dir=1 at cycle 5 (STABLE_CYCLES=4); move=1; fire=0 throughout.
- keycode glitches 0x1A for 2 cycles then back to 0x00 → key_code_q stays 0x00; dir unchanged; no accept_evt.
- Space held 40 frames, COOLDOWN_FRAMES=15, macro off → exactly 1 fire pulse. Release, re-press after frame 20 → second pulse.
- Same as the previous test with TANK_KEY_AUTOFIRE_EN → pulses at accept, +15 frames, +30 frames (3 total). Reset at frame 5 → next accept fires immediately.
- Enter press/release twice → paused 0→1→0. While paused=1, hold W → move=0, dir=0. Space → no fire.
- Space press in F_COOL coinciding with a frame_tick that brings cooldown to 0 → no fire that cycle; state moves to F_WAIT_REL (macro off).

Source files
------------

// File: rtl/tank_key_pkg.sv
// Shared keycode constants, direction/fire-state enums and the direction
// decode helper for the player-1 tank key decoder.
package tank_key_pkg;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    F_IDLE     = 2'd0,
    F_COOL     = 2'd1,
    F_WAIT_REL = 2'd2
  } fire_state_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_decode_t;

  function automatic dir_decode_t is_dir_code(input logic [7:0] code);
    dir_decode_t r;
    r.valid = 1'b1;
    r.dir   = DIR_UP;
    case (code)
      KC_W:    r.dir = DIR_UP;
      KC_D:    r.dir = DIR_RIGHT;
      KC_S:    r.dir = DIR_DOWN;
      KC_A:    r.dir = DIR_LEFT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_stable_filter.sv
// Glitch filter for the PIO keycode: a code is accepted once it has been
// unchanged for STABLE_CYCLES registered samples.
module key_stable_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] keycode,
  output logic [WIDTH-1:0] key_code_q,
  output logic             accept_evt,
  output logic [WIDTH-1:0] accept_code
);

  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] cand;
  logic [7:0]       count;
  logic [7:0]       count_next;

  // accept_evt is high in the cycle whose closing edge loads key_code_q,
  // so the top can update dir/paused/fire on that very same edge.
  always_comb begin
    count_next = '0;
    if (raw_q == cand) begin
      count_next = (count == 8'hFF) ? count : count + 8'd1;
    end
    accept_evt  = (count_next == 8'(STABLE_CYCLES - 1)) && (raw_q != key_code_q);
    accept_code = raw_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      raw_q      <= '0;
      cand       <= '0;
      count      <= '0;
      key_code_q <= '0;
    end else begin
      raw_q <= keycode;
      cand  <= raw_q;
      count <= count_next;
      if (accept_evt) key_code_q <= raw_q;
    end
  end

endmodule

// File: rtl/tank_key_decoder.sv
// Player-1 tank control from filtered HID keycodes: direction, move, pause
// toggle and frame-based fire cooldown. Define TANK_KEY_AUTOFIRE_EN for autofire.
module tank_key_decoder
  import tank_key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [1:0] dir,
  output logic       move,
  output logic       fire,
  output logic       paused,
  output logic [7:0] key_code_q
);

  logic        accept_evt;
  logic [7:0]  accept_code;
  logic [7:0]  kq_next;
  logic        paused_next;
  dir_decode_t acc_dec;
  dir_decode_t kq_dec;
  dir_t        dir_q;

  fire_state_t state;
  fire_state_t state_next;
  logic [7:0]  cooldown;
  logic [7:0]  cool_next;
  logic        fire_next;

  key_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .WIDTH        (8)
  ) u_filter (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .key_code_q (key_code_q),
    .accept_evt (accept_evt),
    .accept_code(accept_code)
  );

  always_comb begin
    kq_next     = accept_evt ? accept_code : key_code_q;
    paused_next = paused ^ (accept_evt && (accept_code == KC_ENTER));
    acc_dec     = is_dir_code(accept_code);
    kq_dec      = is_dir_code(kq_next);
  end

  // Events are judged against pre-update state; the end-of-cooldown decision
  // looks at kq_next so a Space accepted on that same edge counts as held.
  always_comb begin
    state_next = state;
    cool_next  = cooldown;
    fire_next  = 1'b0;
    unique case (state)
      F_IDLE: begin
        if (accept_evt && (accept_code == KC_SPACE) && !paused) begin
          fire_next  = 1'b1;
          cool_next  = 8'(COOLDOWN_FRAMES);
          state_next = F_COOL;
        end
      end
      F_COOL: begin
        if (frame_tick) begin
          cool_next = cooldown - 8'd1;
          if (cooldown == 8'd1) begin
`ifdef TANK_KEY_AUTOFIRE_EN
            if ((kq_next == KC_SPACE) && !paused) begin
              fire_next = 1'b1;
              cool_next = 8'(COOLDOWN_FRAMES);
            end else begin
              state_next = F_IDLE;
            end
`else
            state_next = (kq_next == KC_SPACE) ? F_WAIT_REL : F_IDLE;
`endif
          end
        end
      end
      F_WAIT_REL: begin
        if (key_code_q != KC_SPACE) state_next = F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= F_IDLE;
      cooldown <= '0;
      fire     <= 1'b0;
      dir_q    <= DIR_UP;
      paused   <= 1'b0;
      move     <= 1'b0;
    end else begin
      state    <= state_next;
      cooldown <= cool_next;
      fire     <= fire_next;
      paused   <= paused_next;
      move     <= kq_dec.valid && !paused_next;
      if (accept_evt && acc_dec.valid) dir_q <= acc_dec.dir;
    end
  end

  assign dir = dir_q;

endmodule
